// File: rtl/cla_pipe_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
//   GROUP_W         : width of one lookahead group (4 bits).
//   MAX_GROUPS      : largest number of groups one slice may hold.
//   group_gp        : group generate/propagate from bit-level g/p.
//   lookahead_carry : carries into every group of a slice, each one a
//                     flat sum of products of the group P/G terms and the
//                     slice carry-in (no group-to-group ripple).
package cla_pipe_pkg;

  localparam int GROUP_W    = 4;
  localparam int MAX_GROUPS = 16;

  // Returns {G, P} for one 4-bit group.
  function automatic logic [1:0] group_gp(input logic [GROUP_W-1:0] g,
                                          input logic [GROUP_W-1:0] p);
    logic [1:0] gp;
    gp[1] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
            (p[3] & p[2] & p[1] & g[0]);
    gp[0] = &p;
    return gp;
  endfunction

  // c[j] = carry into group j; c[n] is the carry out of n groups.
  // Unused upper groups must be passed in with P = G = 0.
  function automatic logic [MAX_GROUPS:0] lookahead_carry(
      input logic [MAX_GROUPS-1:0] p,
      input logic [MAX_GROUPS-1:0] g,
      input logic                  cin);
    logic [MAX_GROUPS:0] c;
    logic                term;
    for (int j = 0; j <= MAX_GROUPS; j++) begin
      term = cin;
      for (int i = 0; i < j; i++) term = term & p[i];
      c[j] = term;
      for (int i = 0; i < j; i++) begin
        term = g[i];
        for (int m = i + 1; m < j; m++) term = term & p[m];
        c[j] = c[j] | term;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operation / result bundle of cla_pipe_adder.
//   Input side : i_valid, o_ready, i_data_a, i_data_b, i_carry, i_sub, i_tag
//   Output side: o_valid, i_ready, o_sum, o_carry, o_overflow, o_zero, o_tag
// Signal names keep the adder's point of view (i_ = into the adder).
// master: the producer/consumer around the adder; slave: the adder itself.
interface cla_pipe_adder_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);

  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_data_a;
  logic [WIDTH-1:0] i_data_b;
  logic             i_carry;
  logic             i_sub;
  logic [TAG_W-1:0] i_tag;

  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_sum;
  logic             o_carry;
  logic             o_overflow;
  logic             o_zero;
  logic [TAG_W-1:0] o_tag;

  modport master (
    output i_valid, i_data_a, i_data_b, i_carry, i_sub, i_tag, i_ready,
    input  o_ready, o_valid, o_sum, o_carry, o_overflow, o_zero, o_tag
  );

  modport slave (
    input  i_valid, i_data_a, i_data_b, i_carry, i_sub, i_tag, i_ready,
    output o_ready, o_valid, o_sum, o_carry, o_overflow, o_zero, o_tag
  );

endinterface

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group.
//   a, b : group operands
//   cin  : carry into the group (from the slice lookahead network)
//   sum  : group sum
//   p, g : group propagate / generate, independent of cin
module cla_group4
  import cla_pipe_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               cin,
  output logic [GROUP_W-1:0] sum,
  output logic               p,
  output logic               g
);

  logic [GROUP_W-1:0] bit_g;
  logic [GROUP_W-1:0] bit_p;
  logic [GROUP_W-1:0] c;
  logic [1:0]         gp;

  assign bit_g = a & b;
  assign bit_p = a ^ b;

  assign c[0] = cin;
  assign c[1] = bit_g[0] | (bit_p[0] & cin);
  assign c[2] = bit_g[1] | (bit_p[1] & bit_g[0]) | (bit_p[1] & bit_p[0] & cin);
  assign c[3] = bit_g[2] | (bit_p[2] & bit_g[1]) | (bit_p[2] & bit_p[1] & bit_g[0]) |
                (bit_p[2] & bit_p[1] & bit_p[0] & cin);

  assign sum = bit_p ^ c;

  assign gp = group_gp(bit_g, bit_p);
  assign g  = gp[1];
  assign p  = gp[0];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// A WIDTH-bit operation is split into STAGES slices of WIDTH/STAGES bits;
// slice k is computed in pipeline stage k, from the carry registered by
// stage k-1. The stage STAGES-1 registers drive the outputs directly.
//   i_clk, i_rst : clock, synchronous active-high reset
//   io (slave)   : operation in (i_valid/o_ready, operands, carry, sub, tag)
//                  result out (o_valid/i_ready, sum, carry, overflow, zero, tag)
// Optional feature: define CLA_PIPE_FLAGS_EN to generate o_overflow and
// o_zero; without it both are tied to 0.
module cla_pipe_adder
  import cla_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  cla_pipe_adder_if.slave io
);

  localparam int S  = WIDTH / STAGES;
  localparam int GN = S / GROUP_W;

  if ((STAGES < 1) || (TAG_W < 1) || ((WIDTH % (GROUP_W * STAGES)) != 0) ||
      (GN > MAX_GROUPS)) begin : g_bad_cfg
    $error("cla_pipe_adder: WIDTH must be a multiple of 4*STAGES (slice <= 64 bits)");
  end

  logic             advance;
  logic [WIDTH-1:0] a_p   [STAGES];
  logic [WIDTH-1:0] b_p   [STAGES];
  logic [WIDTH-1:0] sum_p [STAGES];
  logic             cy_p  [STAGES];
  logic [TAG_W-1:0] tag_p [STAGES];
  logic             vld_p [STAGES];
`ifdef CLA_PIPE_FLAGS_EN
  logic             zero_p [STAGES];
  logic             ovf_p;
`endif

  // Global stall: the whole pipe moves only when the output slot frees up.
  assign advance    = ~vld_p[STAGES-1] | io.i_ready;
  assign io.o_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int BASE = k * S;
    localparam bit LAST = (k == STAGES - 1);

    logic [WIDTH-1:0] a_k;
    logic [WIDTH-1:0] b_k;
    logic [WIDTH-1:0] sum_k;
    logic [WIDTH-1:0] sum_nxt;
    logic             cin_k;
    logic             vld_k;
    logic [TAG_W-1:0] tag_k;
    logic [GN-1:0]    grp_p;
    logic [GN-1:0]    grp_g;
    logic [GN:0]      grp_c;
    logic [S-1:0]     slice_sum;

    if (k == 0) begin : g_src_port
      // Subtraction is A + ~B + 1; the external carry is ignored then.
      assign a_k   = io.i_data_a;
      assign b_k   = io.i_sub ? ~io.i_data_b : io.i_data_b;
      assign cin_k = io.i_sub | io.i_carry;
      assign sum_k = '0;
      assign tag_k = io.i_tag;
      assign vld_k = io.i_valid;
    end else begin : g_src_pipe
      assign a_k   = a_p[k-1];
      assign b_k   = b_p[k-1];
      assign cin_k = cy_p[k-1];
      assign sum_k = sum_p[k-1];
      assign tag_k = tag_p[k-1];
      assign vld_k = vld_p[k-1];
    end

    for (genvar j = 0; j < GN; j++) begin : g_grp
      cla_group4 u_grp (
        .a   (a_k[BASE + GROUP_W*j +: GROUP_W]),
        .b   (b_k[BASE + GROUP_W*j +: GROUP_W]),
        .cin (grp_c[j]),
        .sum (slice_sum[GROUP_W*j +: GROUP_W]),
        .p   (grp_p[j]),
        .g   (grp_g[j])
      );
    end

    assign grp_c = (GN+1)'(lookahead_carry(MAX_GROUPS'(grp_p), MAX_GROUPS'(grp_g), cin_k));

    always_comb begin
      sum_nxt             = sum_k;
      sum_nxt[BASE +: S]  = slice_sum;
    end

    // ---- stage k register boundary ----
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        vld_p[k] <= 1'b0;
      end else if (advance) begin
        vld_p[k] <= vld_k;
      end
    end

    // Only the output-facing stage has its data cleared by reset; inner
    // stages are qualified by their valid bits.
    always_ff @(posedge i_clk) begin
      if (i_rst && LAST) begin
        sum_p[k] <= '0;
        cy_p[k]  <= 1'b0;
        tag_p[k] <= '0;
      end else if (advance) begin
        a_p[k]   <= a_k;
        b_p[k]   <= b_k;
        sum_p[k] <= sum_nxt;
        cy_p[k]  <= grp_c[GN];
        tag_p[k] <= tag_k;
      end
    end

`ifdef CLA_PIPE_FLAGS_EN
    // Zero detect accumulates slice by slice so no stage sees a full-width OR.
    logic zero_in;
    if (k == 0) begin : g_zin_port
      assign zero_in = 1'b1;
    end else begin : g_zin_pipe
      assign zero_in = zero_p[k-1];
    end

    always_ff @(posedge i_clk) begin
      if (i_rst && LAST) begin
        zero_p[k] <= 1'b0;
      end else if (advance) begin
        zero_p[k] <= zero_in & ~|slice_sum;
      end
    end

    if (LAST) begin : g_ovf
      // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c.
      logic cin_msb;
      assign cin_msb = slice_sum[S-1] ^ a_k[WIDTH-1] ^ b_k[WIDTH-1];

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          ovf_p <= 1'b0;
        end else if (advance) begin
          ovf_p <= cin_msb ^ grp_c[GN];
        end
      end
    end
`endif
  end

  assign io.o_valid = vld_p[STAGES-1];
  assign io.o_sum   = sum_p[STAGES-1];
  assign io.o_carry = cy_p[STAGES-1];
  assign io.o_tag   = tag_p[STAGES-1];
`ifdef CLA_PIPE_FLAGS_EN
  assign io.o_overflow = ovf_p;
  assign io.o_zero     = zero_p[STAGES-1];
`else
  assign io.o_overflow = 1'b0;
  assign io.o_zero     = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (WIDTH=32, STAGES=4, TAG_W=4).
// Flag expectations follow CLA_PIPE_FLAGS_EN: with the macro undefined the
// overflow and zero outputs are expected to read 0.
module tb_cla_pipe_adder;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;
  localparam int TAG_W  = 4;

`ifdef CLA_PIPE_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cla_pipe_adder_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  cla_pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io    (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [3:0]  tag;
    logic [31:0] sum;
    logic        carry;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vecs [10];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference adder: {carry_out, sum}.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    logic [31:0] bb;
    logic        c0;
    bb = sub ? ~b : b;
    c0 = sub ? 1'b1 : cin;
    return {1'b0, a} + {1'b0, bb} + {32'b0, c0};
  endfunction

  function automatic logic [31:0] seq_a(input int i);
    return 32'h1357_9BDF ^ (32'h1111_1111 * 32'(i));
  endfunction

  function automatic logic [31:0] seq_b(input int i);
    return 32'h0F0F_00FF + (32'h0101_0101 * 32'(i));
  endfunction

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'h3, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 4'h5, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'h6, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 4'h7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 4'h8, 32'h1234_5679, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_1234, 32'h0000_1234, 1'b0, 1'b1, 4'h9, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 1'b0, 4'hA, 32'h0001_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 4'hB, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1, 4'hC, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{32'h00F0_F0F0, 32'h000F_0F0F, 1'b1, 1'b0, 4'hF, 32'h0100_0000, 1'b0, 1'b0, 1'b0};

    // Reset held for two edges while an operation is offered.
    rst          = 1'b1;
    bus.i_valid  = 1'b1;
    bus.i_data_a = 32'hDEAD_BEEF;
    bus.i_data_b = 32'h0000_1111;
    bus.i_carry  = 1'b0;
    bus.i_sub    = 1'b0;
    bus.i_tag    = 4'hA;
    bus.i_ready  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_valid", bus.o_valid, 0);
      check("rst_sum", bus.o_sum, 0);
      check("rst_tag", bus.o_tag, 0);
      check("rst_carry", bus.o_carry, 0);
      check("rst_ovf", bus.o_overflow, 0);
      check("rst_zero", bus.o_zero, 0);
    end
    rst         = 1'b0;
    bus.i_valid = 1'b0;
    #1;
    check("rst_ready", bus.o_ready, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("rst_no_emit", bus.o_valid, 0);
    end

    // Single operations from the table, latency and every output checked.
    for (int v = 0; v < 10; v++) begin
      int lat;
      lat          = 0;
      bus.i_data_a = vecs[v].a;
      bus.i_data_b = vecs[v].b;
      bus.i_carry  = vecs[v].cin;
      bus.i_sub    = vecs[v].sub;
      bus.i_tag    = vecs[v].tag;
      bus.i_valid  = 1'b1;
      for (int n = 1; n <= 10; n++) begin
        step();
        if (n == 1) bus.i_valid = 1'b0;
        if (bus.o_valid === 1'b1) begin
          lat = n;
          break;
        end
      end
      check("vec_latency", lat, STAGES);
      check("vec_sum", bus.o_sum, vecs[v].sum);
      check("vec_carry", bus.o_carry, vecs[v].carry);
      check("vec_ovf", bus.o_overflow, vecs[v].ovf & FLAGS);
      check("vec_zero", bus.o_zero, vecs[v].zero & FLAGS);
      check("vec_tag", bus.o_tag, vecs[v].tag);
      step();
    end

    // Eight back-to-back ops with a 3-cycle stall at the first result.
    begin
      logic [32:0] q_exp [$];
      logic [3:0]  q_tag [$];
      logic [31:0] hold_sum;
      logic [3:0]  hold_tag;
      logic [32:0] e;
      logic [3:0]  et;
      int          issued;
      int          got;
      int          stall;
      int          vcycles;
      bit          seen;
      bit          prev_stall;
      issued     = 0;
      got        = 0;
      stall      = 0;
      vcycles    = 0;
      seen       = 1'b0;
      prev_stall = 1'b0;
      hold_sum   = '0;
      hold_tag   = '0;
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
        if (bus.o_valid === 1'b1 && !seen) begin
          seen  = 1'b1;
          stall = 3;
        end
        bus.i_ready = (stall == 0);
        if (issued < 8) begin
          bus.i_valid  = 1'b1;
          bus.i_data_a = seq_a(issued);
          bus.i_data_b = seq_b(issued);
          bus.i_carry  = issued[1];
          bus.i_sub    = issued[0];
          bus.i_tag    = 4'(issued);
        end else begin
          bus.i_valid = 1'b0;
        end
        #1;
        check("seq_ready", bus.o_ready, (stall == 0));
        if (bus.o_valid === 1'b1) vcycles++;
        if (stall > 0 && prev_stall) begin
          check("stall_hold_sum", bus.o_sum, hold_sum);
          check("stall_hold_tag", bus.o_tag, hold_tag);
        end
        if (bus.o_valid === 1'b1 && bus.i_ready) begin
          if (q_exp.size() == 0) begin
            check("seq_extra_result", 1, 0);
          end else begin
            e  = q_exp.pop_front();
            et = q_tag.pop_front();
            check("seq_sum", bus.o_sum, e[31:0]);
            check("seq_carry", bus.o_carry, e[32]);
            check("seq_tag", bus.o_tag, et);
          end
          got++;
        end
        if (bus.i_valid && bus.o_ready === 1'b1) begin
          q_exp.push_back(model(bus.i_data_a, bus.i_data_b, bus.i_carry, bus.i_sub));
          q_tag.push_back(bus.i_tag);
          issued++;
        end
        hold_sum   = bus.o_sum;
        hold_tag   = bus.o_tag;
        prev_stall = (stall > 0);
        if (stall > 0) stall--;
        step();
      end
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      check("seq_count", got, 8);
      check("seq_valid_cycles", vcycles, 11);
    end

    // Three ops in flight, then reset while a fourth is offered.
    for (int i = 0; i < 3; i++) begin
      bus.i_valid  = 1'b1;
      bus.i_data_a = 32'h0000_0100 * 32'(i + 1);
      bus.i_data_b = 32'h0000_0001;
      bus.i_carry  = 1'b0;
      bus.i_sub    = 1'b0;
      bus.i_tag    = 4'(i + 1);
      step();
    end
    rst = 1'b1;
    step();
    rst         = 1'b0;
    bus.i_valid = 1'b0;
    check("midrst_valid", bus.o_valid, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("midrst_stale", bus.o_valid, 0);
      check("midrst_ready", bus.o_ready, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
